// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared definitions for the multi-channel clock divider (clk_div_multi and
//   its per-channel core clk_div_ch).
//
//   Contents:
//     DEFAULT_CNT_W / DEFAULT_DIV / DEFAULT_HIGH : default parameter values
//     CFG_W      : internal counter/config width; the widest supported CNT_W
//     cnt_t      : counter / period / high-time word
//     ch_cfg_t   : one channel configuration (period and high time)
//     clamp_cfg  : legalises a requested configuration
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned DEFAULT_CNT_W = 31;
    localparam int unsigned DEFAULT_DIV   = 10_000_000;
    localparam int unsigned DEFAULT_HIGH  = 5_000_000;

    // Channels keep their state at this width; narrower CNT_W values are
    // zero-extended at the write port, so the upper bits stay zero.
    localparam int unsigned CFG_W = 32;

    typedef logic [CFG_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t div;   // period in clk cycles (>= 2)
        cnt_t high;  // cycles of q=1 at the end of each period (<= div-1)
    } ch_cfg_t;

    // Period below 2 cannot produce a tick distinct from the wrap, so it is
    // raised to 2; the high time is then limited against the clamped period.
    function automatic ch_cfg_t clamp_cfg(input cnt_t div, input cnt_t high);
        ch_cfg_t c;
        c.div  = (div < cnt_t'(2)) ? cnt_t'(2) : div;
        c.high = (high > (c.div - cnt_t'(1))) ? (c.div - cnt_t'(1)) : high;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
//   One divider channel: free-running period counter, active and shadow
//   configuration registers, registered square wave and tick.
//
//   Optional build macro: CLK_DIV_SYNC_RESTART_EN adds the sync input which
//   restarts the counter at 0 and applies any pending configuration.
//
//   Ports:
//     clk     in   system clock
//     rst     in   asynchronous reset, active-high
//     sync    in   restart request (only with CLK_DIV_SYNC_RESTART_EN)
//     en      in   run enable; low holds cnt at 0 and forces q/tick low
//     wr      in   configuration write for this channel (already decoded)
//     wr_cfg  in   clamped configuration accompanying wr
//     q       out  square wave, low phase first then high phase
//     tick    out  one-cycle pulse on the last cycle of each period
//     pend    out  shadow configuration waiting for the next wrap
// -----------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DEF_DIV  = DEFAULT_DIV,
    parameter int unsigned DEF_HIGH = DEFAULT_HIGH
) (
    input  logic    clk,
    input  logic    rst,
`ifdef CLK_DIV_SYNC_RESTART_EN
    input  logic    sync,
`endif
    input  logic    en,
    input  logic    wr,
    input  ch_cfg_t wr_cfg,
    output logic    q,
    output logic    tick,
    output logic    pend
);

    localparam ch_cfg_t DEF_CFG = '{div: cnt_t'(DEF_DIV), high: cnt_t'(DEF_HIGH)};

    cnt_t    cnt;
    cnt_t    cnt_nxt;
    ch_cfg_t act;
    ch_cfg_t act_nxt;
    ch_cfg_t shd;
    ch_cfg_t shd_nxt;
    logic    pend_nxt;
    logic    q_nxt;
    logic    tick_nxt;
    logic    last;
    logic    reload;

    assign last = (cnt == (act.div - cnt_t'(1)));

    // reload marks every edge at which a new period begins at cnt=0; those
    // are the only edges where the active configuration may change.
`ifdef CLK_DIV_SYNC_RESTART_EN
    assign reload = !en || sync || last;
`else
    assign reload = !en || last;
`endif

    always_comb begin
        cnt_nxt  = cnt + cnt_t'(1);
        act_nxt  = act;
        shd_nxt  = wr ? wr_cfg : shd;
        pend_nxt = pend | wr;

        if (reload) begin
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
            // A write landing on a reload edge goes straight to the active
            // register, so it governs the period that starts at this edge.
            if (wr) begin
                act_nxt = wr_cfg;
            end else if (pend) begin
                act_nxt = shd;
            end
        end

        // Outputs are evaluated against the counter value and configuration
        // that will be live after this edge, keeping q/tick aligned to cnt.
        q_nxt    = en && (cnt_nxt >= (act_nxt.div - act_nxt.high));
        tick_nxt = en && (cnt_nxt == (act_nxt.div - cnt_t'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            act  <= DEF_CFG;
            shd  <= DEF_CFG;
            pend <= 1'b0;
            q    <= 1'b0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            act  <= act_nxt;
            shd  <= shd_nxt;
            pend <= pend_nxt;
            q    <= q_nxt;
            tick <= tick_nxt;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   N_CH independent programmable clock-enable / square-wave generators.
//   Outputs are meant as clock enables and slow waveforms, never as clocks.
//
//   Optional build macro: CLK_DIV_SYNC_RESTART_EN adds sync_in, which
//   restarts every enabled channel at cnt=0 so all channels become
//   phase-aligned.
//
//   Parameters:
//     N_CH      number of channels (>= 1)
//     CNT_W     width of wr_div / wr_high (<= clk_div_pkg::CFG_W)
//     DEF_DIV   period loaded at reset (>= 2)
//     DEF_HIGH  high time loaded at reset (< DEF_DIV)
//
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous reset, active-high
//     sync_in  in   phase-align all channels (only with the macro)
//     en       in   per-channel run enable
//     wr_en    in   one-cycle configuration write strobe
//     wr_ch    in   target channel
//     wr_div   in   requested period in cycles
//     wr_high  in   requested high time in cycles
//     wr_ack   out  one-cycle pulse: write accepted
//     wr_err   out  one-cycle pulse: write rejected (wr_ch >= N_CH)
//     pend     out  per-channel shadow configuration pending
//     q        out  per-channel square wave
//     tick     out  per-channel one-cycle pulse per period
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int unsigned N_CH     = 4,
    parameter  int unsigned CNT_W    = DEFAULT_CNT_W,
    parameter  int unsigned DEF_DIV  = DEFAULT_DIV,
    parameter  int unsigned DEF_HIGH = DEFAULT_HIGH,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLK_DIV_SYNC_RESTART_EN
    input  logic             sync_in,
`endif
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [N_CH-1:0]  pend,
    output logic [N_CH-1:0]  q,
    output logic [N_CH-1:0]  tick
);

    logic    wr_valid;
    ch_cfg_t wr_cfg;

    // wr_ch can encode values beyond the last channel when N_CH is not a
    // power of two; those writes are refused.
    assign wr_valid = wr_en && (32'(wr_ch) < N_CH);
    assign wr_cfg   = clamp_cfg(cnt_t'(wr_div), cnt_t'(wr_high));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_valid;
            wr_err <= wr_en && !wr_valid;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic ch_wr;

        assign ch_wr = wr_valid && (32'(wr_ch) == i);

        clk_div_ch #(
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
`ifdef CLK_DIV_SYNC_RESTART_EN
            .sync   (sync_in),
`endif
            .en     (en[i]),
            .wr     (ch_wr),
            .wr_cfg (wr_cfg),
            .q      (q[i]),
            .tick   (tick[i]),
            .pend   (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sync_in = 1'b0;
    logic [2:0] en = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_div = '0;
    logic [7:0] wr_high = '0;
    logic       wr_ack;
    logic       wr_err;
    logic [2:0] pend;
    logic [2:0] q;
    logic [2:0] tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Three channels so that wr_ch is 2 bits wide and wr_ch=3 is an
    // out-of-range channel; channel 2 is kept disabled throughout.
    clk_div_multi #(
        .N_CH     (3),
        .CNT_W    (8),
        .DEF_DIV  (10),
        .DEF_HIGH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_SYNC_RESTART_EN
        .sync_in (sync_in),
`endif
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .pend    (pend),
        .q       (q),
        .tick    (tick)
    );

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s[%0d]: got %0h expected %0h", tag, idx, got, want);
        end
    endtask

    // Runs n clock edges; after each edge compares channel 0/1 q and tick
    // against bit patterns written left-to-right in time (channel 2 must stay
    // low), plus a constant pend value and idle wr_ack/wr_err.
    task automatic win(input string tag, input int n,
                       input logic [31:0] q0, input logic [31:0] t0,
                       input logic [31:0] q1, input logic [31:0] t1,
                       input logic [2:0] pend_e);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".q"},    i, 32'(q),    32'({1'b0, q1[n-1-i], q0[n-1-i]}));
            chk({tag, ".tick"}, i, 32'(tick), 32'({1'b0, t1[n-1-i], t0[n-1-i]}));
            chk({tag, ".pend"}, i, 32'(pend), 32'(pend_e));
            chk({tag, ".ack"},  i, 32'(wr_ack), 32'd0);
            chk({tag, ".err"},  i, 32'(wr_err), 32'd0);
        end
    endtask

    // One-cycle write, then checks of everything visible after that edge.
    task automatic wr_cycle(input string tag, input logic [1:0] ch,
                            input logic [7:0] dv, input logic [7:0] hi,
                            input logic ack_e, input logic err_e,
                            input logic [2:0] pend_e, input logic [2:0] q_e,
                            input logic [2:0] tick_e);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = dv;
        wr_high = hi;
        @(negedge clk);
        wr_en = 1'b0;
        chk({tag, ".ack"},  0, 32'(wr_ack), 32'(ack_e));
        chk({tag, ".err"},  0, 32'(wr_err), 32'(err_e));
        chk({tag, ".pend"}, 0, 32'(pend),   32'(pend_e));
        chk({tag, ".q"},    0, 32'(q),      32'(q_e));
        chk({tag, ".tick"}, 0, 32'(tick),   32'(tick_e));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".q"},    0, 32'(q),      32'd0);
        chk({tag, ".tick"}, 0, 32'(tick),   32'd0);
        chk({tag, ".pend"}, 0, 32'(pend),   32'd0);
        chk({tag, ".ack"},  0, 32'(wr_ack), 32'd0);
        chk({tag, ".err"},  0, 32'(wr_err), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        rst = 1'b0;
        en  = 3'b011;
        // Default 10/4: six low cycles, four high, tick on the last high.
        win("def", 20, 20'b00000111100000011110, 20'b00000000100000000010,
                       20'b00000111100000011110, 20'b00000000100000000010, 3'b000);
        win("to_cnt3", 3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

        // Mid-period write ch0 4/1: held in shadow until the 9->0 edge.
        wr_cycle("wr_ch0_mid", 2'd0, 8'd4, 8'd1, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000);
        win("pend0", 5, 5'b01111, 5'b00001, 5'b01111, 5'b00001, 3'b001);
        win("div4", 11, 11'b00010001000, 11'b00010001000,
                        11'b00000011110, 11'b00000000010, 3'b000);

        // ch1 div=1 high=7 clamps to 2/1.
        wr_cycle("wr_ch1_clamp", 2'd1, 8'd1, 8'd7, 1'b1, 1'b0, 3'b010, 3'b001, 3'b001);
        win("pend1", 8, 8'b00010001, 8'b00010001, 8'b00001111, 8'b00000001, 3'b010);
        win("div2", 8, 8'b00010001, 8'b00010001, 8'b01010101, 8'b01010101, 3'b000);

        // ch0 is at its last count: the write takes effect at this very edge.
        wr_cycle("wr_ch0_wrap", 2'd0, 8'd6, 8'd3, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        win("div6", 12, 12'b001110001110, 12'b000010000010,
                        12'b101010101010, 12'b101010101010, 3'b000);

        // Out-of-range channel is refused and changes nothing.
        wr_cycle("wr_bad_ch", 2'd3, 8'd20, 8'd5, 1'b0, 1'b1, 3'b000, 3'b010, 3'b010);
        win("after_bad", 6, 6'b011100, 6'b000100, 6'b010101, 6'b010101, 3'b000);

        // Pending write to ch0, then disable: pend clears, shadow applies.
        wr_cycle("wr_ch0_8", 2'd0, 8'd8, 8'd2, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000);
        en = 3'b010;
        win("dis0", 3, 3'b000, 3'b000, 3'b101, 3'b101, 3'b000);
        en = 3'b011;
        win("div8", 15, 15'b000001100000011, 15'b000000100000001,
                        15'b010101010101010, 15'b010101010101010, 3'b000);

        // Leave ack/pend/q/tick high, then reset asynchronously between edges.
        wr_cycle("wr_ch1_5", 2'd1, 8'd5, 8'd2, 1'b1, 1'b0, 3'b010, 3'b010, 3'b010);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        win("post_rst", 10, 10'b0000011110, 10'b0000000010,
                            10'b0000011110, 10'b0000000010, 3'b000);

`ifdef CLK_DIV_SYNC_RESTART_EN
        // Skew ch1 behind ch0, then realign both with sync_in.
        en = 3'b001;
        win("skew_a", 3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        en = 3'b011;
        win("skew_b", 2, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        sync_in = 1'b1;
        win("sync", 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        sync_in = 1'b0;
        win("aligned", 10, 10'b0000011110, 10'b0000000010,
                           10'b0000011110, 10'b0000000010, 3'b000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
